// File: rtl/neuron_par_if.sv
// Handshake and configuration bus of a single parallel-lane neuron.
// The master side drives beats, weight/bias loads and out_ready; the slave side is the neuron.
interface neuron_par_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4
);
    logic [LANES*DATA_WIDTH-1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        weight_valid;
    logic [31:0]                 weight_value;
    logic                        bias_valid;
    logic [31:0]                 bias_value;
    logic [31:0]                 config_layer_num;
    logic [31:0]                 config_neuron_num;
    logic [DATA_WIDTH-1:0]       out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;

    modport master (
        output in_data, in_valid, weight_valid, weight_value, bias_valid, bias_value,
               config_layer_num, config_neuron_num, out_ready,
        input  in_ready, out_data, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid, weight_valid, weight_value, bias_valid, bias_value,
               config_layer_num, config_neuron_num, out_ready,
        output in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/neuron_par.sv
// Fixed-point neuron: LANES-wide multiply-accumulate over NB beats, bias add,
// saturating requantisation and relu/linear activation with an out_valid/out_ready result.
module neuron_par #(
    parameter int    LAYER_NO         = 1,
    parameter int    NEURON_NO        = 0,
    parameter int    NUM_WEIGHT       = 30,
    parameter int    DATA_WIDTH       = 16,
    parameter int    LANES            = 4,
    parameter int    WEIGHT_INT_WIDTH = 1,
    parameter string ACT_TYPE         = "relu"
) (
    input logic          clk,
    input logic          rst,
    neuron_par_if.slave  bus
);

    localparam int NB      = (NUM_WEIGHT + LANES - 1) / LANES;
    localparam int AW      = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW      = $clog2(NB + 1);
    localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW      = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
    localparam int ACC_W   = 2 * DATA_WIDTH;
    localparam int SUM_W   = ACC_W + 4;
    localparam bit IS_RELU = (ACT_TYPE == "relu");

    typedef enum logic [2:0] {S_IDLE, S_ACC, S_BIAS, S_ACT, S_OUT} state_t;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        logic [SUM_W-ACC_W:0] hi;
        hi = v[SUM_W-1:ACC_W-1];
        if (hi == '0 || hi == '1) sat_acc = v[ACC_W-1:0];
        else if (v[SUM_W-1])      sat_acc = {1'b1, {(ACC_W-1){1'b0}}};
        else                      sat_acc = {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    // The field keeps WEIGHT_INT_WIDTH integer bits off the top; the bits dropped above it must be pure sign.
    function automatic logic signed [DATA_WIDTH-1:0] sat_field(input logic signed [ACC_W-1:0] a);
        logic [WEIGHT_INT_WIDTH:0] hi;
        hi = a[ACC_W-1 -: WEIGHT_INT_WIDTH+1];
        if (hi == '0 || hi == '1) sat_field = a[ACC_W-1-WEIGHT_INT_WIDTH -: DATA_WIDTH];
        else if (a[ACC_W-1])      sat_field = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else                      sat_field = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    endfunction

    state_t                        state, state_nx;
    logic [CW-1:0]                 beat_cnt;
    logic [PW-1:0]                 wr_ptr;
    logic [AW-1:0]                 wr_word;
    logic [LW-1:0]                 wr_lane;
    logic                          cfg_hit, accept, in_ready, last_beat, drained, leave_out;
    logic signed [DATA_WIDTH-1:0]  wmem [NB][LANES];
    logic signed [DATA_WIDTH-1:0]  bias_q, out_q;
    logic signed [ACC_W-1:0]       acc;
    logic [LANES-1:0]              lane_en, en_p0;
    logic [LANES*DATA_WIDTH-1:0]   x_p0;
    logic signed [DATA_WIDTH-1:0]  w_p0 [LANES];
    logic signed [ACC_W-1:0]       prod_p1 [LANES];
    logic signed [SUM_W-1:0]       tree_sum;
    logic                          vld_p0, vld_p1, vld_p2;
    logic                          unused_hi_bits;

    assign cfg_hit   = (bus.config_layer_num == 32'(LAYER_NO)) &&
                       (bus.config_neuron_num == 32'(NEURON_NO));
    assign last_beat = (beat_cnt == CW'(NB));
    assign in_ready  = (state == S_IDLE) || (state == S_ACC && !last_beat);
    assign accept    = bus.in_valid && in_ready;
    assign drained   = last_beat && !vld_p0 && !vld_p1 && !vld_p2;
    assign leave_out = (state == S_OUT) && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == S_OUT);
    assign bus.out_data  = out_q;
    assign bus.busy      = (state != S_IDLE);
    assign unused_hi_bits = ^{bus.weight_value[31:DATA_WIDTH], bus.bias_value[31:DATA_WIDTH]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_ACC;
            S_ACC:   if (drained) state_nx = S_BIAS;
            S_BIAS:  state_nx = S_ACT;
            S_ACT:   state_nx = S_OUT;
            S_OUT:   if (bus.out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (bus.weight_valid && cfg_hit) wmem[wr_word][wr_lane] <= bus.weight_value[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            wr_word <= '0;
            wr_lane <= '0;
        end else if (bus.weight_valid && cfg_hit) begin
            if (wr_ptr == PW'(NUM_WEIGHT - 1)) begin
                wr_ptr  <= '0;
                wr_word <= '0;
                wr_lane <= '0;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_lane == LW'(LANES - 1)) begin
                    wr_lane <= '0;
                    wr_word <= wr_word + 1'b1;
                end else begin
                    wr_lane <= wr_lane + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           bias_q <= '0;
        else if (bus.bias_valid && cfg_hit) bias_q <= bus.bias_value[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           beat_cnt <= '0;
        else if (leave_out) beat_cnt <= '0;
        else if (accept)    beat_cnt <= beat_cnt + 1'b1;
    end

    always_comb begin
        lane_en = '0;
        for (int l = 0; l < LANES; l++) lane_en[l] = (int'(beat_cnt) * LANES + l) < NUM_WEIGHT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // p0: capture the beat together with its weight word
    always_ff @(posedge clk) begin
        if (accept) begin
            x_p0  <= bus.in_data;
            en_p0 <= lane_en;
            w_p0  <= wmem[beat_cnt[AW-1:0]];
        end
    end

    // p1: per-lane products, lanes past the last weight forced to zero
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            for (int l = 0; l < LANES; l++)
                prod_p1[l] <= en_p0[l] ? ACC_W'($signed(x_p0[l*DATA_WIDTH +: DATA_WIDTH])) * ACC_W'(w_p0[l])
                                       : '0;
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int l = 0; l < LANES; l++) tree_sum = tree_sum + SUM_W'(prod_p1[l]);
    end

    // p2: adder tree into the saturating accumulator; the bias shares the same clamp
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  acc <= '0;
        else if (leave_out)        acc <= '0;
        else if (vld_p1)           acc <= sat_acc(SUM_W'(acc) + tree_sum);
        else if (state == S_BIAS)  acc <= sat_acc(SUM_W'(acc) + SUM_W'($signed({bias_q, {DATA_WIDTH{1'b0}}})));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                out_q <= '0;
        else if (state == S_ACT) out_q <= (IS_RELU && acc[ACC_W-1]) ? '0 : sat_field(acc);
    end

endmodule

// File: tb/tb_neuron_par.sv
// Directed bench for neuron_par: a relu and a linear instance receive identical stimulus.
module tb_neuron_par;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] in_data;
    logic        in_valid, weight_valid, bias_valid, out_ready;
    logic [31:0] weight_value, bias_value, cfg_layer, cfg_neuron;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    neuron_par_if #(.DATA_WIDTH(16), .LANES(4)) ifr();
    neuron_par_if #(.DATA_WIDTH(16), .LANES(4)) ifl();

    assign ifr.in_data = in_data;            assign ifl.in_data = in_data;
    assign ifr.in_valid = in_valid;          assign ifl.in_valid = in_valid;
    assign ifr.weight_valid = weight_valid;  assign ifl.weight_valid = weight_valid;
    assign ifr.weight_value = weight_value;  assign ifl.weight_value = weight_value;
    assign ifr.bias_valid = bias_valid;      assign ifl.bias_valid = bias_valid;
    assign ifr.bias_value = bias_value;      assign ifl.bias_value = bias_value;
    assign ifr.config_layer_num = cfg_layer; assign ifl.config_layer_num = cfg_layer;
    assign ifr.config_neuron_num = cfg_neuron; assign ifl.config_neuron_num = cfg_neuron;
    assign ifr.out_ready = out_ready;        assign ifl.out_ready = out_ready;

    neuron_par #(.LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(6), .DATA_WIDTH(16), .LANES(4),
                 .WEIGHT_INT_WIDTH(1), .ACT_TYPE("relu"))
        dut_relu (.clk(clk), .rst(rst), .bus(ifr));

    neuron_par #(.LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(6), .DATA_WIDTH(16), .LANES(4),
                 .WEIGHT_INT_WIDTH(1), .ACT_TYPE("linear"))
        dut_lin (.clk(clk), .rst(rst), .bus(ifl));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input logic [15:0] w, input int layer, input int neuron, input int n);
        cfg_layer  = layer;
        cfg_neuron = neuron;
        weight_value = {16'hA5A5, w};
        weight_valid = 1'b1;
        repeat (n) tick();
        weight_valid = 1'b0;
        cfg_layer  = 1;
        cfg_neuron = 0;
    endtask

    task automatic load_bias(input logic [15:0] b, input int neuron);
        cfg_neuron = neuron;
        bias_value = {16'h5A5A, b};
        bias_valid = 1'b1;
        tick();
        bias_valid = 1'b0;
        cfg_neuron = 0;
    endtask

    task automatic send_beat(input logic [63:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ifr.out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_vector(input string name, input logic [63:0] b1, input logic [63:0] b2,
                              input int gap, input logic [15:0] exp_r, input logic [15:0] exp_l);
        int lat;
        send_beat(b1);
        repeat (gap) tick();
        send_beat(b2);
        wait_out(lat);
        n_vec++;
        if (lat != 6) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles, expected 6", name, lat);
        end
        n_vec++;
        if (ifl.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s linear out_valid: got %b, expected 1", name, ifl.out_valid);
        end
        n_vec++;
        if (ifr.out_data !== exp_r) begin
            n_err++;
            $display("FAIL %s relu out_data: got %h, expected %h", name, ifr.out_data, exp_r);
        end
        n_vec++;
        if (ifl.out_data !== exp_l) begin
            n_err++;
            $display("FAIL %s linear out_data: got %h, expected %h", name, ifl.out_data, exp_l);
        end
        tick();
        n_vec++;
        if ({ifr.out_valid, ifr.busy, ifr.in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL %s after handshake {out_valid,busy,in_ready}: got %b, expected 001",
                     name, {ifr.out_valid, ifr.busy, ifr.in_ready});
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({ifr.in_ready, ifr.out_valid, ifr.busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset relu {in_ready,out_valid,busy}: got %b, expected 100",
                     {ifr.in_ready, ifr.out_valid, ifr.busy});
        end
        n_vec++;
        if ({ifl.in_ready, ifl.out_valid, ifl.busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset linear {in_ready,out_valid,busy}: got %b, expected 100",
                     {ifl.in_ready, ifl.out_valid, ifl.busy});
        end
        n_vec++;
        if (ifr.out_data !== 16'h0000 || ifl.out_data !== 16'h0000) begin
            n_err++;
            $display("FAIL reset out_data: got %h/%h, expected 0000", ifr.out_data, ifl.out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load_weights(16'h0100, 1, 0, 6);
        run_vector("basic", {4{16'h0100}}, {4{16'h0100}}, 0, 16'h000C, 16'h000C);
        run_vector("padding", {4{16'h0100}}, {16'h7FFF, 16'h7FFF, 16'h0100, 16'h0100}, 0,
                   16'h000C, 16'h000C);
        run_vector("gap", {4{16'h0100}}, {4{16'h0100}}, 3, 16'h000C, 16'h000C);
    endtask

    task automatic test_patterns();
        run_vector("ramp", {16'h0400, 16'h0300, 16'h0200, 16'h0100},
                   {16'h0000, 16'h0000, 16'h0600, 16'h0500}, 0, 16'h002A, 16'h002A);
        run_vector("negative", {4{16'hFF00}}, {4{16'hFF00}}, 0, 16'h0000, 16'hFFF4);
    endtask

    task automatic test_bias();
        load_bias(16'hFF00, 0);
        run_vector("bias_neg", 64'h0, 64'h0, 0, 16'h0000, 16'hFE00);
        load_bias(16'h0000, 0);
    endtask

    task automatic test_saturation();
        load_weights(16'h7FFF, 1, 0, 6);
        run_vector("sat_pos", {4{16'h7FFF}}, {4{16'h7FFF}}, 0, 16'h7FFF, 16'h7FFF);
        run_vector("sat_neg", {4{16'h8000}}, {4{16'h8000}}, 0, 16'h0000, 16'h8000);
        load_weights(16'h0100, 1, 0, 6);
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send_beat({4{16'h0100}});
        send_beat({4{16'h0100}});
        wait_out(lat);
        n_vec++;
        if (lat != 6) begin
            n_err++;
            $display("FAIL stall latency: got %0d cycles, expected 6", lat);
        end
        in_data  = {4{16'h7FFF}};
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if ({ifr.out_valid, ifr.in_ready, ifl.out_valid} !== 3'b101 ||
                ifr.out_data !== 16'h000C || ifl.out_data !== 16'h000C) begin
                n_err++;
                $display("FAIL stall cycle %0d: valid/ready/valid=%b data=%h/%h, expected 101 000C/000C",
                         i, {ifr.out_valid, ifr.in_ready, ifl.out_valid}, ifr.out_data, ifl.out_data);
            end
        end
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        n_vec++;
        if ({ifr.out_valid, ifr.in_ready, ifr.busy} !== 3'b010) begin
            n_err++;
            $display("FAIL stall release {out_valid,in_ready,busy}: got %b, expected 010",
                     {ifr.out_valid, ifr.in_ready, ifr.busy});
        end
        run_vector("post_stall", {4{16'h0100}}, {4{16'h0100}}, 0, 16'h000C, 16'h000C);
    endtask

    task automatic test_config_filter();
        load_weights(16'h0200, 1, 5, 6);
        load_weights(16'h0200, 2, 0, 6);
        load_bias(16'h4000, 5);
        run_vector("cfg_filter", {4{16'h0100}}, {4{16'h0100}}, 0, 16'h000C, 16'h000C);
    endtask

    task automatic test_reset_abort();
        bit seen;
        send_beat({4{16'h0100}});
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if ({ifr.in_ready, ifr.busy, ifr.out_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL abort reset {in_ready,busy,out_valid}: got %b, expected 100",
                     {ifr.in_ready, ifr.busy, ifr.out_valid});
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ifr.out_valid === 1'b1 || ifl.out_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort out_valid: got an aborted result, expected none");
        end
        n_vec++;
        if (ifr.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort in_ready: got %b, expected 1", ifr.in_ready);
        end
        run_vector("after_abort", {4{16'h0100}}, {4{16'h0100}}, 0, 16'h000C, 16'h000C);
    endtask

    initial begin
        in_data = '0;
        in_valid = 1'b0;
        weight_valid = 1'b0;
        bias_valid = 1'b0;
        weight_value = '0;
        bias_value = '0;
        cfg_layer = 1;
        cfg_neuron = 0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_patterns();
        test_bias();
        test_saturation();
        test_backpressure();
        test_config_filter();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
